// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the custom-opcode MIPS datapath.
// Define MC_ILLEGAL_TRAP_EN to send illegal opcodes to a sticky TRAP state instead of retiring them as NOPs.
module multicycle_control #(
  parameter logic [7:0] OP_RTYPE = 8'd24,
  parameter logic [7:0] OP_LW    = 8'd25,
  parameter logic [7:0] OP_SW    = 8'd26,
  parameter logic [7:0] OP_J     = 8'd27,
  parameter logic [7:0] OP_BEQ   = 8'd28,
  parameter logic [7:0] OP_BNE   = 8'd29,
  parameter logic [7:0] OP_ADDI  = 8'd30,
  parameter logic [7:0] OP_JAL   = 8'd2,
  parameter logic [3:0] FUNCT_JR = 4'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] opcode,
  input  logic [3:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       link,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retired,
  output logic       trap,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_JAL     = 4'd10,
    S_JR      = 4'd11,
    S_ADDIEX  = 4'd12,
    S_ADDIWB  = 4'd13
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP  = 4'd14
`endif
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retired;
    logic       trap;
  } ctrl_t;

  state_e state_q, state_d;
  logic   is_bne_q, is_bne_d;
  logic   is_lw_q, is_lw_d;
  ctrl_t  ctrl, ctrl_out;
  logic   is_jr;

  assign is_jr = (opcode == 8'd0) && (funct == FUNCT_JR);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      is_bne_q <= 1'b0;
      is_lw_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_bne_q <= is_bne_d;
      is_lw_q  <= is_lw_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    ctrl     = '0;
    state_d  = state_q;
    is_bne_d = is_bne_q;
    is_lw_d  = is_lw_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        // The IR is free to change after DECODE, so keep only what later states need.
        is_bne_d = (opcode == OP_BNE);
        is_lw_d  = (opcode == OP_LW);
        if (opcode == OP_LW || opcode == OP_SW)       state_d = S_MEMADDR;
        else if (opcode == OP_RTYPE)                  state_d = S_EXEC;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BRANCH;
        else if (opcode == OP_J)                      state_d = S_JUMP;
        else if (opcode == OP_JAL)                    state_d = S_JAL;
        else if (is_jr)                               state_d = S_JR;
        else if (opcode == OP_ADDI)                   state_d = S_ADDIEX;
        else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          ctrl.retired = 1'b1;
          state_d      = S_FETCH;
`endif
        end
      end
      S_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = is_lw_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retired    = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retired   = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        state_d        = S_RWB;
      end
      S_RWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.retired   = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b01;
        ctrl.pc_src    = 2'b01;
        ctrl.pc_write  = is_bne_q ? ~zero : zero;
        ctrl.retired   = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
        ctrl.retired  = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        ctrl.pc_src    = 2'b10;
        ctrl.pc_write  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.retired   = 1'b1;
        state_d        = S_FETCH;
      end
      S_JR: begin
        ctrl.pc_src   = 2'b11;
        ctrl.pc_write = 1'b1;
        ctrl.retired  = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retired   = 1'b1;
        state_d        = S_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl.trap = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low for the whole reset window, including the cycle it is first raised.
  assign ctrl_out   = reset ? '0 : ctrl;
  assign state      = reset ? 4'd0 : state_q;

  assign pc_write   = ctrl_out.pc_write;
  assign pc_src     = ctrl_out.pc_src;
  assign iord       = ctrl_out.iord;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_write  = ctrl_out.mem_write;
  assign ir_write   = ctrl_out.ir_write;
  assign reg_dst    = ctrl_out.reg_dst;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign reg_write  = ctrl_out.reg_write;
  assign link       = ctrl_out.link;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign retired    = ctrl_out.retired;
  assign trap       = ctrl_out.trap;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized instruction streams
// compared cycle by cycle against an instruction-level step model.
module tb_multicycle_control;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP_MODE = 1'b1;
`else
  localparam bit TRAP_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] opcode = 8'd0;
  logic [3:0] funct = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, link, alu_src_a, retired, trap;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int path[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .link(link), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .retired(retired), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, link, alu_src_a, alu_src_b, alu_op, retired, trap};

  // Instruction-level view: the sequence of steps each instruction class walks through.
  function automatic bit is_illegal(input logic [7:0] op, input logic [3:0] fn);
    case (op)
      8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd30, 8'd2: return 1'b0;
      8'd0:    return (fn != 4'd8);
      default: return 1'b1;
    endcase
  endfunction

  function automatic void build_path(input logic [7:0] op, input logic [3:0] fn);
    path = {0, 1};
    case (op)
      8'd24: path = {path, 6, 7};
      8'd25: path = {path, 2, 3, 4};
      8'd26: path = {path, 2, 5};
      8'd27: path.push_back(9);
      8'd28, 8'd29: path.push_back(8);
      8'd30: path = {path, 12, 13};
      8'd2:  path.push_back(10);
      default: if (!is_illegal(op, fn)) path.push_back(11);
               else if (TRAP_MODE) path.push_back(14);
    endcase
  endfunction

  // Expected control word for one step given the live inputs.
  function automatic logic [17:0] exp_out(input int step, input bit mr, input bit z,
                                          input bit bne, input bit ill);
    logic pw, iord_e, mrd, mwr, irw, rd, m2r, rw, lk, asa, ret, trp;
    logic [1:0] ps, asb, aop;
    {pw, iord_e, mrd, mwr, irw, rd, m2r, rw, lk, asa, ret, trp} = '0;
    {ps, asb, aop} = '0;
    case (step)
      0:  begin mrd = 1; asb = 2'b01; pw = mr; irw = mr; end
      1:  begin asb = 2'b11; ret = ill && !TRAP_MODE; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord_e = 1; end
      4:  begin rw = 1; m2r = 1; ret = 1; end
      5:  begin mwr = 1; iord_e = 1; ret = mr; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; ret = 1; end
      8:  begin asa = 1; aop = 2'b01; ps = 2'b01; ret = 1; pw = bne ? !z : z; end
      9:  begin ps = 2'b10; pw = 1; ret = 1; end
      10: begin ps = 2'b10; pw = 1; rw = 1; lk = 1; ret = 1; end
      11: begin ps = 2'b11; pw = 1; ret = 1; end
      12: begin asa = 1; asb = 2'b10; end
      13: begin rw = 1; ret = 1; end
      14: trp = 1;
      default: ;
    endcase
    return {pw, ps, iord_e, mrd, mwr, irw, rd, m2r, rw, lk, asa, asb, aop, ret, trp};
  endfunction

  task automatic check_cycle(input string name, input int step, input logic [17:0] exp_o,
                             input logic [3:0] exp_s);
    n_checks++;
    if (obs !== exp_o) begin
      n_fail++;
      $display("FAIL %s outputs step %0d: got %b expected %b", name, step, obs, exp_o);
    end
    n_checks++;
    if (state !== exp_s) begin
      n_fail++;
      $display("FAIL %s state step %0d: got %0d expected %0d", name, step, state, exp_s);
    end
  endtask

  task automatic do_reset(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset     = 1'b1;
      mem_ready = 1'($urandom);
      zero      = 1'($urandom);
      opcode    = 8'($urandom);
      funct     = 4'($urandom);
      #1 check_cycle(name, -1, 18'd0, 4'd0);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one instruction; rnd randomizes mem_ready, otherwise only rd_stalls MEMRD stalls occur.
  task automatic run_instr(input string name, input logic [7:0] op, input logic [3:0] fn,
                           input bit z, input bit rnd, input int rd_stalls);
    int idx = 0, cyc = 0, ret_cyc = -1, run = 0, stalls_left = rd_stalls, trap_cyc = 0;
    bit ill, mr, zz;
    ill = is_illegal(op, fn);
    build_path(op, fn);
    while (idx < path.size()) begin
      int step = path[idx];
      if (cyc != 0) @(negedge clk);
      cyc++;
      if (rnd) mr = (run >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      else if (step == 3 && stalls_left > 0) begin mr = 1'b0; stalls_left--; end
      else mr = 1'b1;
      run = mr ? 0 : run + 1;
      zz  = (step == 8) ? z : 1'($urandom);
      mem_ready = mr;
      zero      = zz;
      opcode    = (step == 1) ? op : 8'($urandom);
      funct     = (step == 1) ? fn : 4'($urandom);
      #1;
      check_cycle(name, step, exp_out(step, mr, zz, op == 8'd29, ill), 4'(step));
      if (retired === 1'b1 && ret_cyc < 0) ret_cyc = cyc;
      @(posedge clk);
      if (step == 14) begin
        trap_cyc++;
        if (trap_cyc == 3) break;
      end else if (!((step == 0 || step == 3 || step == 5) && !mr)) idx++;
    end
    n_checks++;
    if (ret_cyc != ((path[path.size()-1] == 14) ? -1 : cyc)) begin
      n_fail++;
      $display("FAIL %s latency: retired at cycle %0d, expected %0d", name, ret_cyc,
               (path[path.size()-1] == 14) ? -1 : cyc);
    end
    if (path[path.size()-1] == 14) do_reset({name, "_trap_reset"}, 1);
    else @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset("reset", 3);
  endtask

  task automatic test_directed();
    run_instr("rtype", 8'd24, 4'd0, 1'b0, 1'b0, 0);
    run_instr("lw_stall2", 8'd25, 4'd0, 1'b0, 1'b0, 2);
    run_instr("sw", 8'd26, 4'd0, 1'b0, 1'b0, 0);
    run_instr("beq_taken", 8'd28, 4'd0, 1'b1, 1'b0, 0);
    run_instr("beq_not", 8'd28, 4'd0, 1'b0, 1'b0, 0);
    run_instr("bne_taken", 8'd29, 4'd0, 1'b0, 1'b0, 0);
    run_instr("bne_not", 8'd29, 4'd0, 1'b1, 1'b0, 0);
    run_instr("j", 8'd27, 4'd0, 1'b0, 1'b0, 0);
    run_instr("jal", 8'd2, 4'd0, 1'b0, 1'b0, 0);
    run_instr("jr", 8'd0, 4'd8, 1'b0, 1'b0, 0);
    run_instr("op0_funct3", 8'd0, 4'd3, 1'b0, 1'b0, 0);
    run_instr("addi", 8'd30, 4'd0, 1'b0, 1'b0, 0);
    run_instr("illegal_ff", 8'hFF, 4'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_sw();
    run_instr("pre_sw", 8'd24, 4'd0, 1'b0, 1'b0, 0);
    build_path(8'd26, 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      mem_ready = (i == 3) ? 1'b0 : 1'b1;
      opcode    = (i == 1) ? 8'd26 : 8'd0;
      funct     = 4'd0;
      #1 check_cycle("mid_sw", path[i], exp_out(path[i], mem_ready, zero, 1'b0, 1'b0), 4'(path[i]));
      @(posedge clk);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset     = 1'b1;
    #1 check_cycle("mid_sw_reset", 5, 18'd0, 4'd0);
    @(posedge clk);
    do_reset("mid_sw_reset_hold", 1);
    run_instr("post_reset_rtype", 8'd24, 4'd0, 1'b0, 1'b1, 0);
    run_instr("post_reset_lw", 8'd25, 4'd0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_random();
    logic [7:0] ops[10] = '{8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd30, 8'd2, 8'd0, 8'hFF};
    for (int i = 0; i < 150; i++) begin
      logic [7:0] op;
      logic [3:0] fn;
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ops[$urandom_range(0, 9)];
      fn = (op == 8'd0 && $urandom_range(0, 1) == 1) ? 4'd8 : 4'($urandom);
      run_instr("random", op, fn, 1'($urandom), 1'b1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_sw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
